// File: rtl/sim_dump_pkg.sv
// sim_dump_pkg
//   Shared types for the simulation end-of-run controller.
//   - dump_state_t : controller state encoding
//   - KIND_REG / KIND_MEM : dump_kind encodings for register / memory beats
package sim_dump_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        DRAIN   = 3'd1,
        DUMP_RF = 3'd2,
        DUMP_DM = 3'd3,
        DONE    = 3'd4
    } dump_state_t;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

endpackage : sim_dump_pkg

// File: rtl/sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset
//     clr  - synchronous clear (same effect as rst, used for phase restarts)
//     en   - count enable
//     cnt  - current count
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    // NOTE: sequential state is written with <= so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/sim_dump_ctrl.sv
// sim_dump_ctrl
//   End-of-run controller for CPU benches. Counts retired instructions and
//   cycles, stops on a retire target (after a drain period) or on a cycle
//   budget, then halts the CPU and streams the register file followed by a
//   data-memory window as a valid/ready word stream.
//
//   Optional feature macro: SIM_DUMP_PC_CHECK_EN
//     Defined   : pc_err flags misaligned or out-of-text-range retiring PCs.
//     Undefined : pc_err is tied to 0.
//
//   Ports:
//     clk, rst          - clock, synchronous active-high reset
//     wb_valid, wb_pc   - WB-stage retire strobe and its PC
//     halt              - freezes the CPU while dumping / done
//     rf_raddr/rf_rdata - register-file read port (combinational data)
//     dm_raddr/dm_rdata - data-memory word read port (combinational data)
//     dump_valid/ready  - output stream handshake
//     dump_kind/index/data - registered beat payload
//     retire_cnt, cycle_cnt - run statistics (saturating, frozen once dumping)
//     timeout           - sticky: run ended on the cycle budget
//     done              - dump finished
//     pc_err            - sticky PC-range error
module sim_dump_ctrl
    import sim_dump_pkg::*;
#(
    parameter int unsigned NREGS        = 32,
    parameter int unsigned DM_WORDS     = 9,
    parameter logic [31:0] DATA_BASE    = 32'h0000_0000,
    parameter logic [31:0] TEXT_BASE    = 32'h0000_3000,
    parameter int unsigned TEXT_WORDS   = 1024,
    parameter int unsigned INST_NUM     = 45,
    parameter int unsigned DRAIN_CYCLES = 20,
    parameter logic [31:0] TIMEOUT      = 32'd10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    output logic        halt,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic [31:0] dm_raddr,
    input  logic [31:0] dm_rdata,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic        dump_kind,
    output logic [7:0]  dump_index,
    output logic [31:0] dump_data,
    output logic [31:0] retire_cnt,
    output logic [31:0] cycle_cnt,
    output logic        timeout,
    output logic        done,
    output logic        pc_err
);

    localparam logic [31:0] INST_TGT  = 32'(INST_NUM);
    localparam logic [31:0] DRAIN_LEN = 32'(DRAIN_CYCLES);
    localparam logic [31:0] RF_LEN    = 32'(NREGS);
    localparam logic [31:0] DM_LEN    = 32'(DM_WORDS);
    localparam logic [31:0] DM_BASE_W = {2'b00, DATA_BASE[31:2]};

    dump_state_t state, state_nxt;
    logic [31:0] beat_cnt;      // drain cycles in DRAIN, next beat to load when dumping
    logic [31:0] phase_len;
    logic        active, in_dump;
    logic        target_hit, budget_hit, timeout_set;
    logic        load, last_accept, cnt_clr, cnt_en;

    assign active    = (state == RUN) || (state == DRAIN);
    assign in_dump   = (state == DUMP_RF) || (state == DUMP_DM);
    assign phase_len = (state == DUMP_DM) ? DM_LEN : RF_LEN;

    // Both stop conditions look at the value the counter takes on this edge,
    // so the transition happens on the same edge the target is reached.
    assign target_hit = (retire_cnt == INST_TGT) ||
                        (wb_valid && (retire_cnt == INST_TGT - 32'd1));
    assign budget_hit = (cycle_cnt == TIMEOUT) || (cycle_cnt == TIMEOUT - 32'd1);

    // A new beat is fetched whenever the output register is empty or being
    // drained this cycle; the read address comes straight from beat_cnt.
    assign load        = in_dump && (!dump_valid || dump_ready) && (beat_cnt < phase_len);
    assign last_accept = in_dump && dump_valid && dump_ready && (beat_cnt == phase_len);

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        timeout_set = 1'b0;
        case (state)
            RUN: begin
                if (target_hit) begin
                    state_nxt = (DRAIN_CYCLES == 0) ? DUMP_RF : DRAIN;
                end else if (budget_hit) begin
                    state_nxt   = DUMP_RF;
                    timeout_set = 1'b1;
                end
            end
            DRAIN:   if (beat_cnt == DRAIN_LEN - 32'd1) state_nxt = DUMP_RF;
            DUMP_RF: if (last_accept) state_nxt = DUMP_DM;
            DUMP_DM: if (last_accept) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    // The shared drain/beat counter restarts on every state change.
    assign cnt_clr = (state_nxt != state);
    assign cnt_en  = (state == DRAIN) || load;

    sat_counter #(.WIDTH(32)) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (active && wb_valid),
        .cnt (retire_cnt)
    );

    sat_counter #(.WIDTH(32)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (active),
        .cnt (cycle_cnt)
    );

    sat_counter #(.WIDTH(32)) u_beat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (beat_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            timeout    <= 1'b0;
            dump_valid <= 1'b0;
            dump_kind  <= KIND_REG;
            dump_index <= '0;
            dump_data  <= '0;
        end else begin
            state <= state_nxt;
            if (timeout_set) begin
                timeout <= 1'b1;
            end
            if (load) begin
                dump_valid <= 1'b1;
                dump_kind  <= (state == DUMP_DM) ? KIND_MEM : KIND_REG;
                dump_index <= beat_cnt[7:0];
                // x0 is hard-wired zero; never trust the register file for it.
                if (state == DUMP_DM) begin
                    dump_data <= dm_rdata;
                end else if (beat_cnt == 32'd0) begin
                    dump_data <= '0;
                end else begin
                    dump_data <= rf_rdata;
                end
            end else if (dump_valid && dump_ready) begin
                dump_valid <= 1'b0;
            end
        end
    end

    assign rf_raddr = (state == DUMP_RF) ? beat_cnt[4:0] : 5'd0;
    assign dm_raddr = (state == DUMP_DM) ? (DM_BASE_W + beat_cnt) : 32'd0;
    assign halt     = in_dump || (state == DONE);
    assign done     = (state == DONE);

`ifdef SIM_DUMP_PC_CHECK_EN
    // 33-bit bounds so a text window ending at 4 GiB does not wrap.
    localparam logic [32:0] TEXT_LO = {1'b0, TEXT_BASE};
    localparam logic [32:0] TEXT_HI = TEXT_LO + (33'(TEXT_WORDS) << 2);

    logic pc_bad;
    logic pc_err_q;

    assign pc_bad = (wb_pc[1:0] != 2'b00) ||
                    ({1'b0, wb_pc} < TEXT_LO) ||
                    ({1'b0, wb_pc} >= TEXT_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_err_q <= 1'b0;
        end else if (active && wb_valid && pc_bad) begin
            pc_err_q <= 1'b1;
        end
    end

    assign pc_err = pc_err_q;
`else
    // wb_pc has no consumer in this build; fold it into a deliberately
    // unused net so the port stays in place for the checked build.
    logic unused_wb_pc;
    assign unused_wb_pc = &{1'b0, wb_pc};
    assign pc_err       = 1'b0;
`endif

endmodule : sim_dump_ctrl

// File: doc/sim_dump_ctrl.md
# sim_dump_ctrl

Parametrised simulation end-of-run controller for the pipelined and multi-cycle CPU benches. It watches the WB stage and counts retired instructions and cycles. It stops the run on a retire target or a timeout, then freezes the CPU and streams the register file and a data-memory window out as a valid/ready word stream. It replaces fixed cycle-count stop logic in per-program benches; the bench only consumes the stream.

## Interface
Parameters:
- NREGS, 32: register-file entries dumped.
- DM_WORDS, 9: data-memory words dumped.
- DATA_BASE, 32'h0000_0000: byte address of the first dumped word.
- TEXT_BASE, 32'h0000_3000: start of the legal PC range.
- TEXT_WORDS, 1024: size of the legal PC range, in words.
- INST_NUM, 45: retire target.
- DRAIN_CYCLES, 20: cycles run after the retire target is reached.
- TIMEOUT, 32'd10000: cycle budget.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  a non-bubble instruction retires this cycle.
- wb_pc  in  32  PC of the retiring instruction.
- halt  out  1  freezes the CPU PC and pipeline registers.
- rf_raddr  out  5  register-file read address.
- rf_rdata  in  32  combinational read data.
- dm_raddr  out  32  data-memory word index.
- dm_rdata  in  32  combinational read data.
- dump_valid  out  1  stream valid.
- dump_ready  in  1  stream ready.
- dump_kind  out  1  0 = register, 1 = memory.
- dump_index  out  8  register number or word offset.
- dump_data  out  32  dumped word.
- retire_cnt  out  32  retired instructions.
- cycle_cnt  out  32  cycles elapsed.
- timeout  out  1  sticky; the cycle budget expired.
- done  out  1  the dump is complete.
- pc_err  out  1  sticky PC-range error (see Configuration).

## Operation
States and transitions:
- RUN → DRAIN when retire_cnt reaches INST_NUM.
- RUN → DUMP_RF when cycle_cnt reaches TIMEOUT; timeout is set.
- If both conditions occur in the same cycle, the retire target wins and timeout stays 0.
- DRAIN → DUMP_RF after DRAIN_CYCLES cycles. TIMEOUT is ignored in DRAIN.
- DUMP_RF → DUMP_DM after beat NREGS-1 is accepted.
- DUMP_DM → DONE after beat DM_WORDS-1 is accepted.
- DONE holds until rst.

Counters:
- retire_cnt increments on wb_valid in RUN and DRAIN.
- cycle_cnt increments every cycle in RUN and DRAIN.
- Both counters saturate at 32'hFFFF_FFFF and freeze from DUMP_RF onward.

Output behaviour:
- halt = 1 in DUMP_RF, DUMP_DM and DONE; 0 otherwise.
- done = 1 only in DONE.
- Register beat 0 always carries data 0, whatever rf_rdata is.
- Memory beat i reads word address DATA_BASE/4 + i and reports dump_index = i.
- Total beats per run: NREGS + DM_WORDS.

## Timing
- Reset values: all outputs 0; state RUN.
- Reset in any state, including mid-dump, returns to RUN with counters cleared and dump_valid low.
- Pipeline fill: the first cycle of each dump phase presents the read address with dump_valid low. The registered beat appears on the next cycle.
- dump_data, dump_kind and dump_index are registered. They load when dump_valid is 0 or a transfer (valid & ready) occurs. The address for the next beat is driven combinationally, so with ready held high the stream carries one beat per cycle.
- While valid & !ready, the outputs hold stable; no beat is dropped or duplicated.
- DRAIN length is exact: halt rises DRAIN_CYCLES cycles after the edge on which retire_cnt becomes INST_NUM.

## Configuration
Macro SIM_DUMP_PC_CHECK_EN:
- Defined: on each wb_valid in RUN or DRAIN, pc_err is set if either condition holds:
  - wb_pc[1:0] != 0;
  - wb_pc is outside [TEXT_BASE, TEXT_BASE + 4*TEXT_WORDS).
- pc_err clears only on rst.
- Not defined: pc_err is tied to 0 and no comparators are built.

## Structure
- Package sim_dump_pkg holds:
  - the state enum (RUN, DRAIN, DUMP_RF, DUMP_DM, DONE);
  - the dump_kind encodings KIND_REG = 0 and KIND_MEM = 1.
- One sub-module, sat_counter, a width-parametrised saturating counter with enable and sync clear. It is instantiated for retire_cnt, cycle_cnt and the drain/beat counter.

## Test plan
- Defaults, 45 back-to-back wb_valid pulses, dump_ready = 1:
  - halt rises 20 cycles after the 45th retire;
  - 41 beats follow, and beat 0 is {kind 0, idx 0, data 0} even with rf_rdata = 32'hDEADBEEF;
  - done = 1 one cycle after beat 40.
- dump_ready low for 3 cycles while beat 5 is valid → dump_index = 5 and its data hold stable; total beats still 41.
- TIMEOUT = 100 with only 10 retires → timeout = 1 and DUMP_RF entered at cycle 100 with no drain; retire_cnt = 10.
- dm_rdata = 32'h1000 + dm_raddr and DATA_BASE = 32'h20 → the memory beat with idx 4 has data 32'h100C.
- rst asserted during beat 20 → the next cycle shows dump_valid = 0, halt = 0, retire_cnt = 0, state RUN.
- With SIM_DUMP_PC_CHECK_EN:
  - wb_pc = 32'h3002 → pc_err = 1, and it stays 1;
  - a separate run with wb_pc = 32'h2FFC → pc_err = 1.
  - Without the macro, both stimuli → pc_err = 0.
